serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL provide port start  input  1  request to begin a subtraction; accepted only in IDLE.
REQ-005 SHALL provide port a  input  WIDTH  minuend, sampled only on the accepting edge.
REQ-006 SHALL provide port b  input  WIDTH  subtrahend, sampled only on the accepting edge.
REQ-007 SHALL provide port diff  output  WIDTH  registered result a-b, modulo 2^WIDTH.
REQ-008 SHALL provide port borrow  output  1  final borrow out (unsigned a < b).
REQ-009 SHALL provide port overflow  output  1  two's-complement signed overflow of a-b.
REQ-010 SHALL provide port zero  output  1  high when diff == 0.
REQ-011 SHALL provide port busy  output  1  high while in SHIFT state.
REQ-012 SHALL provide port done  output  1  one-cycle pulse marking valid results.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 IDLE: on start=1, SHALL latch a and b into internal shift registers, clear bit counter and internal borrow, and go to SHIFT.
REQ-015 SHIFT: each cycle SHALL process one bit, LSB first: d = ai ^ bi ^ bin; bout = (~ai & bi) | (~(ai ^ bi) & bin).
REQ-016 SHIFT: SHALL shift d into the result register MSB end so the full result is LSB-aligned after WIDTH cycles.
REQ-017 SHALL remain in SHIFT for exactly WIDTH cycles, then go to DONE.
REQ-018 On entering DONE, SHALL update diff, borrow, overflow and zero together from the completed operation.
REQ-019 DONE: SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH+1; results valid from that cycle.
REQ-021 overflow SHALL equal (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched operands.
REQ-022 diff, borrow, overflow and zero SHALL hold their last values until the next completed operation, including while busy.
REQ-023 start while in SHIFT or DONE SHALL be ignored, with no queueing; a and b changes outside the accepting edge SHALL have no effect.
REQ-024 start held high continuously SHALL start a new operation on each IDLE cycle, giving one operation per WIDTH+2 cycles.
REQ-025 busy SHALL be high exactly in SHIFT cycles; busy and done SHALL never be high simultaneously.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE and set diff=0, borrow=0, overflow=0, zero=0, busy=0, done=0; it SHALL clear counter, shift registers and internal borrow.
REQ-027 rst SHALL take priority over start in the same cycle; an operation aborted by reset SHALL produce no done pulse.
REQ-028 First start SHALL be accepted on the first edge with rst=0 and start=1.

Verification (WIDTH=8)
REQ-029 Stimulus a=0x05, b=0x03, start for 1 cycle -> busy high for 8 cycles, then done; diff=0x02, borrow=0, overflow=0, zero=0.
REQ-030 Stimulus a=0x03, b=0x05 -> diff=0xFE, borrow=1, overflow=0, zero=0.
REQ-031 Stimulus a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1; then a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
REQ-032 Stimulus a=0xA5, b=0xA5 -> diff=0x00, zero=1, borrow=0; then a=0x00, b=0x00 -> same flags.
REQ-033 Stimulus start with a=0x10, b=0x01; pulse start with a=0xFF, b=0x00 at SHIFT cycle 3 -> ignored, result diff=0x0F; prior outputs held while busy.
REQ-034 Stimulus rst at SHIFT cycle 4 -> next cycle all outputs 0, state IDLE, no done; a following start gives the correct result after WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b one bit per clock, LSB first, and
// presents diff/borrow/overflow/zero together when the operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             d_bit, bout;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ bin_q;
    bout     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    res_next = {d_bit, res_q[WIDTH-1:1]};

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          bin_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_next;
        bin_d = bout;
        cnt_d = cnt_q + CNT_W'(1);
        // The last bit lands in res_next, so results publish on this same edge.
        if (cnt_q == LAST) begin
          diff_d   = res_next;
          borrow_d = bout;
          ovf_d    = (a_msb_q != b_msb_q) & (res_next[WIDTH-1] != a_msb_q);
          zero_d   = (res_next == '0);
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases, reset abort,
// and randomized operands compared against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, diff;
  logic         borrow, overflow, zero, busy, done;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] e_diff;
  logic         e_borrow, e_ovf, e_zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag);
    check({tag, "_diff"}, 64'(diff), 64'(e_diff));
    check({tag, "_borrow"}, 64'(borrow), 64'(e_borrow));
    check({tag, "_ovf"}, 64'(overflow), 64'(e_ovf));
    check({tag, "_zero"}, 64'(zero), 64'(e_zero));
  endtask

  // Called in an IDLE cycle; returns in the following IDLE cycle with start low.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] nd;
    longint       sx, sy, sd;
    nd = x - y;
    sx = $signed(x);
    sy = $signed(y);
    sd = sx - sy;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    for (int i = 0; i < W; i++) begin
      if (i > 0) tick();
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_done_in_shift"}, 64'(done), 64'd0);
      check_results({tag, "_held"});
      // Activity on start/a/b while shifting must not disturb the operation.
      start = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
    end
    e_diff   = nd;
    e_borrow = (x < y);
    e_ovf    = (sd > longint'((64'd1 << (W - 1)) - 1)) || (sd < -longint'(64'd1 << (W - 1)));
    e_zero   = (nd == '0);
    tick();
    check({tag, "_busy_done_state"}, 64'(busy), 64'd0);
    check({tag, "_done_early"}, 64'(done), 64'd0);
    check_results({tag, "_entering_done"});
    start = 1'($urandom_range(0, 1));
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd1);
    check({tag, "_busy_with_done"}, 64'(busy), 64'd0);
    check_results(tag);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    e_diff = '0; e_borrow = 1'b0; e_ovf = 1'b0; e_zero = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_results("rst");
    rst   = 1'b0;
    start = 1'b0;

    run_op("sub_05_03", 8'h05, 8'h03);
    run_op("sub_03_05", 8'h03, 8'h05);
    run_op("sub_80_01", 8'h80, 8'h01);
    run_op("sub_7f_ff", 8'h7F, 8'hFF);
    run_op("sub_a5_a5", 8'hA5, 8'hA5);
    run_op("sub_00_00", 8'h00, 8'h00);
    run_op("sub_10_01", 8'h10, 8'h01);
    run_op("sub_00_ff", 8'h00, 8'hFF);

    // Abort in the fourth SHIFT cycle with start also high: reset must win.
    a = 8'h44;
    b = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    e_diff = '0; e_borrow = 1'b0; e_ovf = 1'b0; e_zero = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check_results("abort");
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      check("abort_no_done", 64'(done), 64'd0);
      check("abort_idle", 64'(busy), 64'd0);
    end
    run_op("after_abort", 8'h22, 8'h33);

    for (int n = 0; n < 20; n++) begin
      run_op("rand", W'($urandom), W'($urandom));
    end

    tick();
    check("final_done_low", 64'(done), 64'd0);
    check("final_busy_low", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
